// File: rtl/conv_task_sequencer.sv
// Layer-level convolution task sequencer: walks oc_grp -> orow -> ic_grp for one latched
// layer descriptor and issues one task per step over a valid/ready handshake.
module conv_task_sequencer #(
    parameter int ATOMIC_C  = 4,
    parameter int ATOMIC_K  = 4,
    parameter int DIM_W     = 12,
    parameter int SIM_DELAY = 1
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                aclken,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                cfg_dw_mode,
    input  logic [DIM_W-1:0]    cfg_ifmap_c_m1,
    input  logic [DIM_W-1:0]    cfg_ofmap_c_m1,
    input  logic [DIM_W-1:0]    cfg_ofmap_h_m1,
    input  logic [1:0]          cfg_stride_m1,
    input  logic [2:0]          cfg_pad_top,
    output logic                busy,
    output logic                done,
    output logic                task_valid,
    input  logic                task_ready,
    output logic [DIM_W-1:0]    task_oc_grp,
    output logic [DIM_W-1:0]    task_ic_grp,
    output logic [DIM_W-1:0]    task_orow,
    output logic [DIM_W:0]      task_irow_base,
    output logic                task_first,
    output logic                task_last,
    output logic [ATOMIC_C-1:0] task_ic_mask,
    output logic [ATOMIC_K-1:0] task_oc_mask
);
    localparam int LOG_C = $clog2(ATOMIC_C);
    localparam int LOG_K = $clog2(ATOMIC_K);

    if (ATOMIC_K < ATOMIC_C) begin : g_bad_atomic
        $error("ATOMIC_K must be >= ATOMIC_C");
    end
    if (SIM_DELAY < 0) begin : g_bad_delay
        $error("SIM_DELAY must be non-negative");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nx;

    logic             dw;
    logic [DIM_W-1:0] ic_last, oc_last, h_last, c_rem, k_rem;
    logic [2:0]       stride;
    logic [2:0]       pad;
    logic [DIM_W-1:0] oc_cnt, ic_cnt, row_cnt;
    logic [DIM_W:0]   irow;
    logic             done_r;

    logic run, hs, start_acc, ic_wrap, row_wrap, oc_wrap, last_hs, ic_is_last;
    logic [ATOMIC_C-1:0] ic_mask;
    logic [ATOMIC_K-1:0] oc_mask;

    assign run       = (state == S_RUN);
    assign hs        = aclken & run & task_ready;
    assign start_acc = aclken & ~run & cfg_start;
    // Depthwise has a single ic step per (oc_grp,orow), so the inner loop always wraps.
    assign ic_wrap   = dw | (ic_cnt == ic_last);
    assign row_wrap  = (row_cnt == h_last);
    assign oc_wrap   = (oc_cnt == oc_last);
    assign last_hs   = hs & ic_wrap & row_wrap & oc_wrap;

    always_comb begin
        state_nx = state;
        if (aclken) begin
            case (state)
                S_IDLE:  if (cfg_start) state_nx = S_RUN;
                S_RUN:   if (last_hs || cfg_abort) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dw      <= 1'b0;
            ic_last <= '0;
            oc_last <= '0;
            h_last  <= '0;
            c_rem   <= '0;
            k_rem   <= '0;
            stride  <= '0;
            pad     <= '0;
            oc_cnt  <= '0;
            ic_cnt  <= '0;
            row_cnt <= '0;
            irow    <= '0;
            done_r  <= 1'b0;
        end else if (aclken) begin
            done_r <= last_hs;
            if (start_acc) begin
                dw      <= cfg_dw_mode;
                ic_last <= cfg_ifmap_c_m1 >> LOG_C;
                oc_last <= cfg_dw_mode ? (cfg_ifmap_c_m1 >> LOG_C) : (cfg_ofmap_c_m1 >> LOG_K);
                h_last  <= cfg_ofmap_h_m1;
                c_rem   <= cfg_ifmap_c_m1 & DIM_W'(ATOMIC_C - 1);
                k_rem   <= cfg_ofmap_c_m1 & DIM_W'(ATOMIC_K - 1);
                stride  <= {1'b0, cfg_stride_m1} + 3'd1;
                pad     <= cfg_pad_top;
                oc_cnt  <= '0;
                ic_cnt  <= '0;
                row_cnt <= '0;
                irow    <= '0 - (DIM_W+1)'(cfg_pad_top);
            end else if (hs) begin
                if (!ic_wrap) begin
                    ic_cnt <= ic_cnt + 1'b1;
                end else begin
                    ic_cnt <= '0;
                    if (!row_wrap) begin
                        row_cnt <= row_cnt + 1'b1;
                        irow    <= irow + (DIM_W+1)'(stride);
                    end else begin
                        row_cnt <= '0;
                        irow    <= '0 - (DIM_W+1)'(pad);
                        oc_cnt  <= oc_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        ic_is_last = dw ? oc_wrap : (ic_cnt == ic_last);
        ic_mask    = '0;
        for (int unsigned i = 0; i < ATOMIC_C; i++)
            ic_mask[i] = !ic_is_last || (DIM_W'(i) <= c_rem);
        oc_mask = '0;
        if (dw) begin
            oc_mask = ATOMIC_K'(ic_mask);
        end else begin
            for (int unsigned i = 0; i < ATOMIC_K; i++)
                oc_mask[i] = !oc_wrap || (DIM_W'(i) <= k_rem);
        end
    end

    assign busy           = run;
    assign task_valid     = run;
    assign done           = done_r;
    assign task_oc_grp    = run ? oc_cnt : '0;
    assign task_ic_grp    = run ? (dw ? oc_cnt : ic_cnt) : '0;
    assign task_orow      = run ? row_cnt : '0;
    assign task_irow_base = run ? irow : '0;
    assign task_first     = run & (dw | (ic_cnt == '0));
    assign task_last      = run & ic_wrap;
    assign task_ic_mask   = run ? ic_mask : '0;
    assign task_oc_mask   = run ? oc_mask : '0;

endmodule

// File: tb/tb_conv_task_sequencer.sv
// Bench for conv_task_sequencer: a queue-based task-list model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_conv_task_sequencer;
    localparam int AC = 4;
    localparam int AK = 4;
    localparam int DW = 12;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          aclken = 1'b1;
    logic          cfg_start = 1'b0, cfg_abort = 1'b0, cfg_dw_mode = 1'b0;
    logic [DW-1:0] cfg_ifmap_c_m1 = '0, cfg_ofmap_c_m1 = '0, cfg_ofmap_h_m1 = '0;
    logic [1:0]    cfg_stride_m1 = '0;
    logic [2:0]    cfg_pad_top = '0;
    logic          busy, done, task_valid;
    logic          task_ready = 1'b0;
    logic [DW-1:0] task_oc_grp, task_ic_grp, task_orow;
    logic [DW:0]   task_irow_base;
    logic          task_first, task_last;
    logic [AC-1:0] task_ic_mask;
    logic [AK-1:0] task_oc_mask;

    conv_task_sequencer #(.ATOMIC_C(AC), .ATOMIC_K(AK), .DIM_W(DW), .SIM_DELAY(1)) dut (
        .aclk(aclk), .areset(areset), .aclken(aclken),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_dw_mode(cfg_dw_mode),
        .cfg_ifmap_c_m1(cfg_ifmap_c_m1), .cfg_ofmap_c_m1(cfg_ofmap_c_m1),
        .cfg_ofmap_h_m1(cfg_ofmap_h_m1), .cfg_stride_m1(cfg_stride_m1),
        .cfg_pad_top(cfg_pad_top), .busy(busy), .done(done),
        .task_valid(task_valid), .task_ready(task_ready),
        .task_oc_grp(task_oc_grp), .task_ic_grp(task_ic_grp), .task_orow(task_orow),
        .task_irow_base(task_irow_base), .task_first(task_first), .task_last(task_last),
        .task_ic_mask(task_ic_mask), .task_oc_mask(task_oc_mask)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int oc; int ic; int row; int irow; int first; int last; int icm; int ocm;
    } task_t;

    task_t q[$];
    int    n_checks = 0, n_errors = 0;
    int    hs_count = 0, done_count = 0;
    bit    m_busy = 0, m_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic int lanes(input int is_last, input int rem, input int atomic);
        return is_last ? ((1 << (rem + 1)) - 1) : ((1 << atomic) - 1);
    endfunction

    // Expected task list of one layer, straight from the loop-nest definition.
    function automatic void build(input bit dwm, input int c_m1, input int k_m1,
                                  input int h_m1, input int s_m1, input int pad);
        task_t t;
        int ngc = c_m1 / AC + 1;
        int ngk = k_m1 / AK + 1;
        q.delete();
        if (dwm) begin
            for (int g = 0; g < ngc; g++)
                for (int r = 0; r <= h_m1; r++) begin
                    t.oc = g; t.ic = g; t.row = r; t.irow = r * (s_m1 + 1) - pad;
                    t.first = 1; t.last = 1;
                    t.icm = lanes(g == ngc - 1, c_m1 % AC, AC); t.ocm = t.icm;
                    q.push_back(t);
                end
        end else begin
            for (int o = 0; o < ngk; o++)
                for (int r = 0; r <= h_m1; r++)
                    for (int i = 0; i < ngc; i++) begin
                        t.oc = o; t.ic = i; t.row = r; t.irow = r * (s_m1 + 1) - pad;
                        t.first = (i == 0); t.last = (i == ngc - 1);
                        t.icm = lanes(i == ngc - 1, c_m1 % AC, AC);
                        t.ocm = lanes(o == ngk - 1, k_m1 % AK, AK);
                        q.push_back(t);
                    end
        end
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge aclk) begin
        if (areset) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_valid", 32'(task_valid), 0);
            chk("rst_fields", 32'({task_oc_grp, task_ic_grp, task_orow} != '0), 0);
            chk("rst_fields2", 32'({task_irow_base, task_first, task_last, task_ic_mask, task_oc_mask} != '0), 0);
            m_busy = 0; m_done = 0; q.delete();
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("valid", 32'(task_valid), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            if (m_busy && q.size() > 0) begin
                chk("oc_grp", 32'(task_oc_grp), q[0].oc);
                chk("ic_grp", 32'(task_ic_grp), q[0].ic);
                chk("orow", 32'(task_orow), q[0].row);
                chk("irow_base", $signed(task_irow_base), q[0].irow);
                chk("first", 32'(task_first), q[0].first);
                chk("last", 32'(task_last), q[0].last);
                chk("ic_mask", 32'(task_ic_mask), q[0].icm);
                chk("oc_mask", 32'(task_oc_mask), q[0].ocm);
            end
            if (done) done_count++;
            if (aclken && task_valid && task_ready) hs_count++;
            if (aclken) begin
                m_done = 0;
                if (m_busy) begin
                    if (task_ready && q.size() > 0) begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin m_busy = 0; m_done = 1; end
                        else if (cfg_abort) begin m_busy = 0; q.delete(); end
                    end else if (cfg_abort) begin
                        m_busy = 0; q.delete();
                    end
                end else if (cfg_start) begin
                    build(cfg_dw_mode, int'(cfg_ifmap_c_m1), int'(cfg_ofmap_c_m1),
                          int'(cfg_ofmap_h_m1), int'(cfg_stride_m1), int'(cfg_pad_top));
                    m_busy = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_layer(input bit dwm, input int c_m1, input int k_m1,
                               input int h_m1, input int s_m1, input int pad);
        cfg_dw_mode    = dwm;
        cfg_ifmap_c_m1 = DW'(c_m1);
        cfg_ofmap_c_m1 = DW'(k_m1);
        cfg_ofmap_h_m1 = DW'(h_m1);
        cfg_stride_m1  = 2'(s_m1);
        cfg_pad_top    = 3'(pad);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic run_to_idle(input bit rnd, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            task_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        chk("idle_reached", 32'(busy), 0);
        task_ready = 1'b1;
        step();
    endtask

    int hs0, dn0;

    initial begin
        step(); step();
        areset = 1'b0;
        step();

        // 1: normal conv, always ready
        task_ready = 1'b1;
        hs0 = hs_count; dn0 = done_count;
        start_layer(0, 5, 7, 1, 0, 1);
        chk("t1_valid", 32'(task_valid), 1);
        chk("t1_irow0", $signed(task_irow_base), -1);
        chk("t1_icm0", 32'(task_ic_mask), 32'hF);
        chk("t1_first0", 32'(task_first), 1);
        step();
        chk("t1_ic1", 32'(task_ic_grp), 1);
        chk("t1_icm1", 32'(task_ic_mask), 32'h3);
        chk("t1_last1", 32'(task_last), 1);
        run_to_idle(0, 50);
        chk("t1_hs", hs_count - hs0, 8);
        chk("t1_done", done_count - dn0, 1);

        // 2: depthwise C=5, OH=3
        hs0 = hs_count; dn0 = done_count;
        start_layer(1, 4, 0, 2, 0, 0);
        step(); step(); step();
        chk("t2_oc", 32'(task_oc_grp), 1);
        chk("t2_ic", 32'(task_ic_grp), 1);
        chk("t2_icm", 32'(task_ic_mask), 32'h1);
        chk("t2_ocm", 32'(task_oc_mask), 32'h1);
        chk("t2_fl", 32'({task_first, task_last}), 32'h3);
        run_to_idle(0, 50);
        chk("t2_hs", hs_count - hs0, 6);
        chk("t2_done", done_count - dn0, 1);

        // 3: case 1 under random backpressure
        hs0 = hs_count; dn0 = done_count;
        task_ready = 1'b0;
        start_layer(0, 5, 7, 1, 0, 1);
        run_to_idle(1, 400);
        chk("t3_hs", hs_count - hs0, 8);
        chk("t3_done", done_count - dn0, 1);

        // 4: abort after three handshakes, then restart
        dn0 = done_count;
        start_layer(0, 5, 7, 1, 0, 1);
        step(); step(); step();
        task_ready = 1'b0; cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_valid", 32'(task_valid), 0);
        step();
        chk("t4_nodone", done_count - dn0, 0);
        task_ready = 1'b1;
        start_layer(0, 5, 7, 1, 0, 1);
        chk("t4_restart", 32'({task_oc_grp, task_ic_grp, task_orow}), 0);
        chk("t4_first", 32'(task_first), 1);
        run_to_idle(0, 50);
        chk("t4_done", done_count - dn0, 1);

        // 5: clock enable low and start while busy
        hs0 = hs_count; dn0 = done_count;
        start_layer(0, 5, 7, 1, 0, 1);
        step(); step();
        aclken = 1'b0;
        cfg_dw_mode = 1'b1; cfg_ifmap_c_m1 = DW'(20); cfg_start = 1'b1;
        repeat (5) step();
        chk("t5_hold", hs_count - hs0, 2);
        chk("t5_ic", 32'(task_ic_grp), 0);
        chk("t5_row", 32'(task_orow), 1);
        aclken = 1'b1;
        step();
        cfg_start = 1'b0;
        run_to_idle(0, 50);
        chk("t5_hs", hs_count - hs0, 8);
        chk("t5_done", done_count - dn0, 1);

        // 6: stride 2, no padding, then asynchronous reset mid-run
        start_layer(0, 3, 3, 2, 1, 0);
        chk("t6_irow0", $signed(task_irow_base), 0);
        step();
        chk("t6_irow1", $signed(task_irow_base), 2);
        step();
        chk("t6_irow2", $signed(task_irow_base), 4);
        run_to_idle(0, 20);
        dn0 = done_count;
        start_layer(0, 5, 7, 1, 0, 1);
        step();
        #2 areset = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_valid", 32'(task_valid), 0);
        chk("t6_rst_fields", 32'({task_ic_grp, task_ic_mask, task_oc_mask, task_first, task_last} != '0), 0);
        step();
        areset = 1'b0;
        step(); step();
        chk("t6_nodone", done_count - dn0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
